// File: rtl/rgb2ycbcr_csc.sv
// rgb2ycbcr_csc: 3-stage RGB to gray/YCbCr/binary/bypass colour-space converter
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   rgb_vsync    frame sync; its rising edge latches mode_sel / bin_thresh
//   rgb_clken    pixel clock enable (out_data forced to zero when delayed copy is low)
//   rgb_valid    pixel valid
//   rgb_data     {R,G,B}, DW bits each, R in the MSBs
//   mode_sel     requested mode: 0 gray, 1 YCbCr, 2 binary, 3 bypass
//   bin_thresh   binary-mode threshold applied to Y
//   out_vsync, out_clken, out_valid   inputs delayed by 3 cycles
//   out_data     converted pixel, 3 cycles after rgb_data
//   mode_active  mode currently latched for new frames
//
// Build option: define RGB2YCBCR_CSC_ROUND_EN to round half up before the
// fractional shift; otherwise the shift truncates.
module rgb2ycbcr_csc #(
    parameter int DW   = 8,
    parameter int FRAC = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rgb_vsync,
    input  logic            rgb_clken,
    input  logic            rgb_valid,
    input  logic [3*DW-1:0] rgb_data,
    input  logic [1:0]      mode_sel,
    input  logic [DW-1:0]   bin_thresh,
    output logic            out_vsync,
    output logic            out_clken,
    output logic            out_valid,
    output logic [3*DW-1:0] out_data,
    output logic [1:0]      mode_active
);
    localparam int PW  = DW + FRAC;
    localparam int ACC = DW + FRAC + 2;

    // Coefficient magnitudes are defined at 8 fractional bits and rescaled to FRAC.
    function automatic logic [FRAC-1:0] kf(input int c8);
        return FRAC'((c8 * (2 ** FRAC) + 128) / 256);
    endfunction

    // Order: Y(R,G,B), Cb(R,G,B), Cr(R,G,B); signs applied in the sum stage.
    localparam logic [FRAC-1:0] K [9] = '{kf(77), kf(150), kf(29),
                                          kf(43), kf(85),  kf(128),
                                          kf(128), kf(107), kf(21)};

    localparam logic signed [ACC-1:0] OFF  = ACC'(2 ** (DW - 1 + FRAC));
    localparam logic signed [ACC-1:0] MAXV = ACC'(2 ** DW - 1);
`ifdef RGB2YCBCR_CSC_ROUND_EN
    localparam logic signed [ACC-1:0] RND  = ACC'(2 ** (FRAC - 1));
`else
    localparam logic signed [ACC-1:0] RND  = '0;
`endif

    function automatic logic signed [ACC-1:0] ext(input logic [PW-1:0] p);
        return $signed({2'b00, p});
    endfunction

    function automatic logic [DW-1:0] clamp(input logic signed [ACC-1:0] s);
        logic signed [ACC-1:0] t;
        t = s >>> FRAC;
        return (t < 0) ? '0 : ((t > MAXV) ? '1 : t[DW-1:0]);
    endfunction

    logic            r_vs_d;
    logic [DW-1:0]   r_thresh;
    logic            w_rise;
    logic [1:0]      w_mode;
    logic [DW-1:0]   w_thr;
    logic [DW-1:0]   w_c [3];

    logic [PW-1:0]   r_p [9];
    logic [2:0]      r_ctl1, r_ctl2;
    logic [3*DW-1:0] r_rgb1, r_rgb2;
    logic [1:0]      r_mode1, r_mode2;
    logic [DW-1:0]   r_thr1, r_thr2;
    logic signed [ACC-1:0] r_y, r_cb, r_cr;

    logic [DW-1:0]   w_y, w_cb, w_cr;
    logic [3*DW-1:0] w_res;

    assign w_c[0] = rgb_data[3*DW-1 -: DW];
    assign w_c[1] = rgb_data[2*DW-1 -: DW];
    assign w_c[2] = rgb_data[DW-1:0];

    // A pixel sampled in the capture cycle already uses the newly latched settings.
    assign w_rise = rgb_vsync & ~r_vs_d;
    assign w_mode = w_rise ? mode_sel   : mode_active;
    assign w_thr  = w_rise ? bin_thresh : r_thresh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d      <= 1'b0;
            mode_active <= 2'd0;
            r_thresh    <= '0;
        end else begin
            r_vs_d      <= rgb_vsync;
            mode_active <= w_mode;
            r_thresh    <= w_thr;
        end
    end

    // Stage 1: unsigned coefficient products plus sideband.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) r_p[i] <= '0;
            r_ctl1  <= '0;
            r_rgb1  <= '0;
            r_mode1 <= '0;
            r_thr1  <= '0;
        end else begin
            for (int i = 0; i < 9; i++) r_p[i] <= PW'(w_c[i % 3]) * PW'(K[i]);
            r_ctl1  <= {rgb_vsync, rgb_clken, rgb_valid};
            r_rgb1  <= rgb_data;
            r_mode1 <= w_mode;
            r_thr1  <= w_thr;
        end
    end

    // Stage 2: signed sums with chroma offset and optional rounding constant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_cb    <= '0;
            r_cr    <= '0;
            r_ctl2  <= '0;
            r_rgb2  <= '0;
            r_mode2 <= '0;
            r_thr2  <= '0;
        end else begin
            r_y     <= ext(r_p[0]) + ext(r_p[1]) + ext(r_p[2]) + RND;
            r_cb    <= OFF + RND - ext(r_p[3]) - ext(r_p[4]) + ext(r_p[5]);
            r_cr    <= OFF + RND + ext(r_p[6]) - ext(r_p[7]) - ext(r_p[8]);
            r_ctl2  <= r_ctl1;
            r_rgb2  <= r_rgb1;
            r_mode2 <= r_mode1;
            r_thr2  <= r_thr1;
        end
    end

    // Stage 3: shift, clamp, mode mux.
    assign w_y  = clamp(r_y);
    assign w_cb = clamp(r_cb);
    assign w_cr = clamp(r_cr);

    always_comb begin
        w_res = (r_mode2 == 2'd0) ? {w_y, w_y, w_y} :
                (r_mode2 == 2'd1) ? {w_y, w_cb, w_cr} :
                (r_mode2 == 2'd2) ? ((w_y >= r_thr2) ? '1 : '0) :
                r_rgb2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vsync <= 1'b0;
            out_clken <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_vsync <= r_ctl2[2];
            out_clken <= r_ctl2[1];
            out_valid <= r_ctl2[0];
            out_data  <= r_ctl2[1] ? w_res : '0;
        end
    end
endmodule

// File: tb/tb_rgb2ycbcr_csc.sv
// tb_rgb2ycbcr_csc: scoreboard bench for rgb2ycbcr_csc (DW=8, FRAC=8)
module tb_rgb2ycbcr_csc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rgb_vsync = 1'b0, rgb_clken = 1'b0, rgb_valid = 1'b0;
    logic [23:0] rgb_data = '0;
    logic [1:0]  mode_sel = '0;
    logic [7:0]  bin_thresh = '0;
    logic        out_vsync, out_clken, out_valid;
    logic [23:0] out_data;
    logic [1:0]  mode_active;

    rgb2ycbcr_csc #(.DW(8), .FRAC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .rgb_vsync(rgb_vsync), .rgb_clken(rgb_clken), .rgb_valid(rgb_valid),
        .rgb_data(rgb_data), .mode_sel(mode_sel), .bin_thresh(bin_thresh),
        .out_vsync(out_vsync), .out_clken(out_clken), .out_valid(out_valid),
        .out_data(out_data), .mode_active(mode_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        bit          vs;
        bit          ck;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit         m_pvs = 0;
    logic [1:0] m_mode = 0;
    logic [7:0] m_thr = 0;

`ifdef RGB2YCBCR_CSC_ROUND_EN
    localparam int RND = 128;
`else
    localparam int RND = 0;
`endif

    function automatic int clip(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    // Reference conversion straight from the published integer coefficients.
    function automatic logic [23:0] model(input logic [23:0] d, input logic [1:0] m,
                                          input logic [7:0] t, input bit ck);
        int r, g, b, y, cb, cr;
        r  = int'(d[23:16]);
        g  = int'(d[15:8]);
        b  = int'(d[7:0]);
        y  = clip((77 * r + 150 * g + 29 * b + RND) >>> 8);
        cb = clip((-43 * r - 85 * g + 128 * b + 32768 + RND) >>> 8);
        cr = clip((128 * r - 107 * g - 21 * b + 32768 + RND) >>> 8);
        if (!ck) return 24'h0;
        case (m)
            2'd0:    return {y[7:0], y[7:0], y[7:0]};
            2'd1:    return {y[7:0], cb[7:0], cr[7:0]};
            2'd2:    return (y >= int'(t)) ? 24'hFFFFFF : 24'h0;
            default: return d;
        endcase
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: every valid output must match the oldest outstanding pixel, 3 cycles on.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got data=%h vs=%0b ck=%0b, required none", out_data, out_vsync, out_clken);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.data || out_vsync !== e.vs || out_clken !== e.ck || cyc != e.cyc + 3) begin
                    failures++;
                    $display("FAIL pixel got data=%h vs=%0b ck=%0b lag=%0d, required data=%h vs=%0b ck=%0b lag=3",
                             out_data, out_vsync, out_clken, cyc - e.cyc, e.data, e.vs, e.ck);
                end
            end
        end
    end

    task automatic drive(input bit vs, input bit ck, input bit vl, input logic [23:0] d,
                         input logic [1:0] ms, input logic [7:0] th);
        @(negedge clk);
        checks++;
        if (mode_active !== m_mode) begin
            failures++;
            $display("FAIL mode_active got %0d required %0d", mode_active, m_mode);
        end
        rgb_vsync = vs; rgb_clken = ck; rgb_valid = vl; rgb_data = d;
        mode_sel = ms; bin_thresh = th;
        if (vs && !m_pvs) begin
            m_mode = ms;
            m_thr  = th;
        end
        m_pvs = vs;
        if (vl) sb.push_back('{model(d, m_mode, m_thr, ck), vs, ck, cyc});
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (out_data !== 24'h0 || out_valid !== 1'b0 || out_clken !== 1'b0 ||
            out_vsync !== 1'b0 || mode_active !== 2'd0) begin
            failures++;
            $display("FAIL %s got data=%h v=%0b ck=%0b vs=%0b mode=%0d, required all zero",
                     tag, out_data, out_valid, out_clken, out_vsync, mode_active);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        rgb_vsync = 0; rgb_clken = 0; rgb_valid = 0; rgb_data = '0;
        mode_sel = 0; bin_thresh = 0;
        #1 check_reset_outputs("reset_async");
        sb.delete();
        m_pvs = 0; m_mode = 0; m_thr = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit vs;
        logic [1:0] ms;
        logic [7:0] th;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        // Latch YCbCr, then saturation corner pixels.
        drive(1, 1, 0, 24'h0, 2'd1, 8'h00);
        drive(1, 1, 1, 24'hFFFFFF, 2'd1, 8'h00);
        drive(0, 1, 1, 24'hFF0000, 2'd1, 8'h00);
        drive(0, 1, 1, 24'h000000, 2'd1, 8'h00);
        drive(0, 1, 1, 24'h0000FF, 2'd1, 8'h00);
        // Binary mode threshold 0x50.
        drive(1, 1, 1, 24'hFF0000, 2'd2, 8'h50);
        drive(0, 1, 1, 24'hFFFFFF, 2'd2, 8'h50);
        drive(0, 1, 1, 24'h505050, 2'd2, 8'h50);
        // Gray latched, mode_sel changed mid-frame, then next vsync rise.
        drive(0, 1, 1, 24'h102030, 2'd0, 8'h00);
        drive(1, 1, 1, 24'h406080, 2'd0, 8'h00);
        drive(1, 1, 1, 24'h112233, 2'd1, 8'h00);
        drive(0, 1, 1, 24'h445566, 2'd1, 8'h00);
        drive(1, 1, 1, 24'h778899, 2'd1, 8'h00);
        drive(1, 1, 1, 24'hAABBCC, 2'd2, 8'h10);
        // Bypass with clken toggling.
        drive(0, 1, 1, 24'h000000, 2'd3, 8'h00);
        drive(1, 1, 1, 24'h123456, 2'd3, 8'h00);
        drive(1, 0, 1, 24'hABCDEF, 2'd3, 8'h00);
        drive(0, 1, 1, 24'hABCDEF, 2'd3, 8'h00);
        drive(0, 0, 1, 24'h123456, 2'd3, 8'h00);
        // Random traffic with occasional frame syncs and mode/threshold churn.
        vs = 0; ms = 0; th = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 11) == 0) vs = ~vs;
            if ($urandom_range(0, 3) == 0) ms = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) th = 8'($urandom);
            drive(vs, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 24'($urandom), ms, th);
            if (n == 300) do_reset();
        end
        // Reset mid-stream with pixels in flight.
        drive(1, 1, 1, 24'hFFFFFF, 2'd1, 8'h00);
        drive(0, 1, 1, 24'h808080, 2'd1, 8'h00);
        do_reset();
        drive(0, 1, 1, 24'h336699, 2'd1, 8'h00);
        drive(0, 1, 1, 24'hFF0000, 2'd3, 8'h00);
        repeat (6) drive(0, 0, 0, 24'h0, 2'd0, 8'h00);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d outstanding pixels, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rgb2ycbcr_csc.md
RGB2YCBCR_CSC -- requirements
Module: rgb2ycbcr_csc

Interface
REQ-001 Parameter DW, default 8, SHALL set bits per colour component (legal 8..12).
REQ-002 Parameter FRAC, default 8, SHALL set coefficient fractional bits (coefficients = round(c*2^FRAC)).
REQ-003 clk  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 rgb_vsync  input  1  frame sync; rgb_clken  input  1  pixel clock enable; rgb_valid  input  1  data valid.
REQ-006 rgb_data  input  3*DW  pixel {R,G,B}, R in MSBs.
REQ-007 mode_sel  input  2  requested mode: 0 gray, 1 YCbCr, 2 binary, 3 bypass.
REQ-008 bin_thresh  input  DW  binary-mode threshold on Y.
REQ-009 out_vsync, out_clken, out_valid  output  1 each  inputs delayed to match data.
REQ-010 out_data  output  3*DW  result; mode_active  output  2  mode currently latched for new frames.

Function
REQ-011 Y = 77R+150G+29B; Cb = -43R-85G+128B+2^(DW-1+FRAC); Cr = 128R-107G-21B+2^(DW-1+FRAC) (FRAC=8 values; other FRAC rescaled), accumulated signed at DW+FRAC+2 bits, no intermediate overflow.
REQ-012 Each sum SHALL be shifted right by FRAC then clamped to [0, 2^DW-1].
REQ-013 Pipeline SHALL be 3 stages: products, sums, shift/clamp/mode mux; out_* SHALL lag rgb_* by exactly 3 cycles, pipeline advancing every clk regardless of rgb_clken.
REQ-014 Mode outputs: 0 {Y,Y,Y}; 1 {Y,Cb,Cr}; 2 all-ones ×3 if Y >= bin_thresh else zero; 3 rgb_data delayed 3 cycles unchanged.
REQ-015 out_data SHALL be zero whenever out_clken is 0.
REQ-016 mode_sel and bin_thresh SHALL be captured into mode_active/thresh registers only in the cycle rgb_vsync rises (registered 0 then input 1); changes at any other time SHALL have no effect.
REQ-017 The captured mode and threshold SHALL travel down the pipeline with each pixel, so a pixel sampled before the capture edge exits under the old mode and every pixel sampled from the capture cycle on exits under the new one.
REQ-018 rgb_vsync high continuously SHALL cause one capture only; simultaneous vsync rise and mode_sel change SHALL capture the new value present that cycle.

Reset
REQ-019 rst_n low SHALL asynchronously clear all pipeline registers, out_vsync/out_clken/out_valid/out_data to 0, mode_active to 0 (gray), threshold to 0, vsync edge register to 0.
REQ-020 Reset mid-frame SHALL discard in-flight pixels; first valid output appears 3 cycles after the first post-reset rgb_clken; mode stays gray until next vsync rise.

Configuration
REQ-021 Macro RGB2YCBCR_CSC_ROUND_EN defined: 2^(FRAC-1) SHALL be added to each sum before the shift (round half up), clamp still applied.
REQ-022 Macro undefined: shift SHALL truncate; latency and interface unchanged.

Verification (DW=8, FRAC=8)
REQ-023 Mode 1, rgb_data 0xFFFFFF, clken=1 -> 3 cycles later out_data 0xFF8080, both macro settings.
REQ-024 Mode 1, 0xFF0000 -> truncate 0x4C55FF; with ROUND_EN 0x4D55FF (Cr 256 clamped to 0xFF).
REQ-025 Mode 2, bin_thresh 0x50, ROUND_EN, pixels 0xFF0000 then 0xFFFFFF -> 0x000000 then 0xFFFFFF.
REQ-026 Mode 0 latched, mode_sel set to 1 mid-frame -> output stays gray; after next vsync rise, pixels sampled from that cycle output {Y,Cb,Cr}, mode_active = 1; earlier in-flight pixels remain gray.
REQ-027 Mode 3, stream 0x123456, 0xABCDEF with clken toggling -> identical data 3 cycles later, 0x000000 where out_clken=0.
REQ-028 rst_n pulsed low mid-stream -> all outputs 0 immediately, mode_active 0, no stale pixel emerges after release.
